pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
Parametrised program-counter generator for the next-generation core. It supersedes the simple next-PC mux with:
- a boot/run/halt state machine
- stall hold
- prioritised trap redirect, with the faulting PC captured
- misaligned branch-target detection
- a retired-fetch counter

It sits at the head of the fetch stage, drives the instruction memory address, and feeds PC+INC to the writeback mux for link-register writes.

Parameters:
XLEN, 32, width of PC, targets and EPC
RESET_VEC, 32'h0000_0000, PC value loaded by reset
TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned target
INC, 4, sequential increment in bytes
CNT_W, 32, width of fetch counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_stall  in  1  hold current PC (pipeline stall)
i_br_taken  in  1  branch/jump redirect request
i_br_target  in  XLEN  redirect target (ALU result)
i_trap  in  1  exception/interrupt redirect request
i_halt  in  1  request halt (e.g. ebreak, debug)
i_resume  in  1  leave halt
o_pc  out  XLEN  current fetch PC
o_pc4  out  XLEN  o_pc + INC, combinational
o_pc_valid  out  1  o_pc is a valid fetch address
o_misalign  out  1  one-cycle pulse: rejected misaligned target
o_epc  out  XLEN  PC captured at last trap/misalign
o_state  out  2  00 BOOT, 01 RUN, 10 HALT
o_fetch_cnt  out  CNT_W  count of PC advances in RUN

Behaviour:
Clocking and reset:
- Single clock.
- Reset is synchronous and active-high: i_rst sampled on the rising edge of i_clk.

Reset values, applied at any time including mid-operation:
- o_pc = RESET_VEC
- o_state = BOOT
- o_pc_valid = 0
- o_misalign = 0
- o_epc = 0
- o_fetch_cnt = 0
- i_rst overrides every other input.

BOOT:
- Lasts exactly one cycle; inputs are ignored.
- Next state RUN; o_pc stays RESET_VEC; o_pc_valid goes 1 with RUN.

RUN, next-PC priority (highest first), evaluated each edge:
1. i_trap: o_pc <= TRAP_VEC, o_epc <= o_pc. Ignores i_stall.
2. i_br_taken with i_br_target[1:0] != 0: o_pc <= TRAP_VEC, o_epc <= o_pc, o_misalign = 1 for the following cycle. Ignores i_stall.
3. i_stall: o_pc holds.
4. i_halt: state <= HALT, o_pc holds, o_pc_valid <= 0.
5. i_br_taken, aligned: o_pc <= i_br_target.
6. Otherwise: o_pc <= o_pc + INC.

RUN arithmetic and counter:
- Additions are modulo 2^XLEN; the PC wraps from all-ones region to 0 without a flag.
- o_fetch_cnt increments by 1 on every RUN edge where o_pc is updated by cases 5 or 6. Traps, stalls, halts and reset do not count.
- o_fetch_cnt wraps at 2^CNT_W.

HALT:
- o_pc holds; o_pc_valid = 0.
- i_trap: state <= RUN, o_pc <= TRAP_VEC, o_epc <= o_pc. Trap has priority over i_resume.
- i_resume: state <= RUN, o_pc_valid <= 1, o_pc unchanged. Fetch resumes at the held PC.
- i_br_taken and i_stall are ignored.

Outputs and latency:
- o_pc4 is combinational from the o_pc register.
- All other outputs are registered.
- Redirect latency is one cycle: a target presented at edge N is on o_pc after edge N.

Test Plan:
1. Reset release: hold i_rst 2 cycles, then release. Required: BOOT for 1 cycle with o_pc=0x0, valid=0; then RUN with o_pc sequence 0x0, 0x4, 0x8; o_pc4=0xC when o_pc=0x8; o_fetch_cnt=2 at o_pc=0x8.
2. Branch and stall: at o_pc=0x10 assert i_br_taken with target 0x200 → o_pc=0x200. Then assert i_stall 3 cycles with i_br_taken=1, target 0x300 → o_pc stays 0x200 and the counter is frozen for those cycles. Release i_stall → o_pc=0x300.
3. Misaligned target: at o_pc=0x40 present target 0x102 with i_stall=1 → o_pc=0x100, o_epc=0x40, o_misalign high exactly 1 cycle, counter unchanged.
4. Trap versus branch: at o_pc=0x80 assert i_trap and an aligned branch to 0x500 together → o_pc=0x100, o_epc=0x80.
5. Halt/resume:
   - At o_pc=0x24 assert i_halt → o_state=HALT, o_pc_valid=0, o_pc=0x24 for 5 cycles with branches ignored.
   - Assert i_resume → RUN, valid=1, then o_pc=0x28.
   - Repeat the halt; this time assert i_trap and i_resume together → o_pc=0x100, o_epc=0x24.
6. Wrap and mid-operation reset:
   - Branch to 0xFFFF_FFFC → next o_pc=0x0.
   - Assert i_rst while i_trap=1 → o_pc=RESET_VEC, BOOT, o_epc=0, o_fetch_cnt=0.
   - With CNT_W=4, 16 advances → o_fetch_cnt wraps to 0.

Source files
------------

// File: rtl/pc_gen_unit.sv
// Program-counter generator at the head of fetch: boot/run/halt control, stall hold,
// prioritised trap and misaligned-target redirect with EPC capture, and a retired-fetch counter.
module pc_gen_unit #(
  parameter int unsigned          XLEN      = 32,
  parameter logic [XLEN-1:0]      RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0]      TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned          INC       = 4,
  parameter int unsigned          CNT_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_br_taken,
  input  logic [XLEN-1:0]   i_br_target,
  input  logic              i_trap,
  input  logic              i_halt,
  input  logic              i_resume,
  output logic [XLEN-1:0]   o_pc,
  output logic [XLEN-1:0]   o_pc4,
  output logic              o_pc_valid,
  output logic              o_misalign,
  output logic [XLEN-1:0]   o_epc,
  output logic [1:0]        o_state,
  output logic [CNT_W-1:0]  o_fetch_cnt
);

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic               valid_q, valid_d;
  logic               misalign_q, misalign_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    pc_inc;
  logic               bad_target;

  assign pc_inc     = pc_q + XLEN'(INC);
  assign bad_target = i_br_taken && (i_br_target[1:0] != 2'b00);

  // State register and all datapath flops.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // every flop here is reset, there is no memory array that could skip it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic. A halt request only takes effect when nothing of higher priority fires.
  // NOTE: each always_comb assigns defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (!i_trap && !bad_target && !i_stall && i_halt) state_d = S_HALT;
      end
      S_HALT: begin
        if (i_trap || i_resume) state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Next-PC, EPC, misalign pulse and counter; redirects beat stall, stall beats halt.
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (i_trap) begin
          pc_d  = TRAP_VEC;
          epc_d = pc_q;
        end else if (bad_target) begin
          pc_d       = TRAP_VEC;
          epc_d      = pc_q;
          misalign_d = 1'b1;
        end else if (!i_stall && !i_halt) begin
          pc_d  = i_br_taken ? i_br_target : pc_inc;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HALT: begin
        if (i_trap) begin
          pc_d  = TRAP_VEC;
          epc_d = pc_q;
        end
      end
      default: ;
    endcase
    valid_d = (state_d == S_RUN);
  end

  assign o_pc        = pc_q;
  assign o_pc4       = pc_inc;
  assign o_pc_valid  = valid_q;
  assign o_misalign  = misalign_q;
  assign o_epc       = epc_q;
  assign o_state     = state_q;
  assign o_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed vector table, hand-written halt/wrap/reset
// sequences, then randomized stimulus checked against a behavioural model.
module tb_pc_gen_unit;

  localparam int unsigned   XLEN  = 32;
  localparam int unsigned   CNT_W = 4;
  localparam logic [31:0]   RV    = 32'h0000_0000;
  localparam logic [31:0]   TV    = 32'h0000_0100;
  localparam logic [1:0]    BOOT  = 2'b00;
  localparam logic [1:0]    RUN   = 2'b01;
  localparam logic [1:0]    HALT  = 2'b10;

  logic              i_clk = 1'b0;
  logic              i_rst, i_stall, i_br_taken, i_trap, i_halt, i_resume;
  logic [XLEN-1:0]   i_br_target;
  logic [XLEN-1:0]   o_pc, o_pc4, o_epc;
  logic              o_pc_valid, o_misalign;
  logic [1:0]        o_state;
  logic [CNT_W-1:0]  o_fetch_cnt;

  always #5 i_clk = ~i_clk;

  pc_gen_unit #(
    .XLEN(XLEN), .RESET_VEC(RV), .TRAP_VEC(TV), .INC(4), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_br_taken(i_br_taken),
    .i_br_target(i_br_target), .i_trap(i_trap), .i_halt(i_halt), .i_resume(i_resume),
    .o_pc(o_pc), .o_pc4(o_pc4), .o_pc_valid(o_pc_valid), .o_misalign(o_misalign),
    .o_epc(o_epc), .o_state(o_state), .o_fetch_cnt(o_fetch_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: architectural state after each edge.
  logic [31:0] m_pc  = RV;
  logic [31:0] m_epc = '0;
  logic [1:0]  m_st  = BOOT;
  logic        m_mis = 1'b0;
  int          m_cnt = 0;

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] tgt;
    logic        trap, halt, resume;
    logic [31:0] pc;
    logic [1:0]  st;
    logic        valid, mis;
    logic [31:0] epc;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, stall, br, input logic [31:0] tgt,
                            input logic trap, halt, resume);
    bit misaligned;
    misaligned = br && (tgt % 4 != 0);
    m_mis = 1'b0;
    if (rst) begin
      m_pc = RV; m_st = BOOT; m_epc = 0; m_cnt = 0;
    end else if (m_st == BOOT) begin
      m_st = RUN;
    end else if (m_st == RUN) begin
      if (trap || misaligned) begin
        m_epc = m_pc;
        m_pc  = TV;
        m_mis = !trap;
      end else if (stall) begin
        // PC held
      end else if (halt) begin
        m_st = HALT;
      end else begin
        m_pc  = br ? tgt : m_pc + 4;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
    end else begin
      if (trap) begin
        m_epc = m_pc; m_pc = TV; m_st = RUN;
      end else if (resume) begin
        m_st = RUN;
      end
    end
  endtask

  // Apply inputs, advance the model, clock once and sample 1 time unit after the edge.
  task automatic drive(input logic rst, stall, br, input logic [31:0] tgt,
                       input logic trap, halt, resume);
    i_rst = rst; i_stall = stall; i_br_taken = br; i_br_target = tgt;
    i_trap = trap; i_halt = halt; i_resume = resume;
    model_step(rst, stall, br, tgt, trap, halt, resume);
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] pc, input logic [1:0] st,
                            input logic valid, mis, input logic [31:0] epc, input logic [3:0] cnt);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    check({tag, ".pc"},    o_pc, pc);
    check({tag, ".pc4"},   o_pc4, pc4);
    check({tag, ".state"}, 32'(o_state), 32'(st));
    check({tag, ".valid"}, 32'(o_pc_valid), 32'(valid));
    check({tag, ".mis"},   32'(o_misalign), 32'(mis));
    check({tag, ".epc"},   o_epc, epc);
    check({tag, ".cnt"},   32'(o_fetch_cnt), 32'(cnt));
  endtask

  function automatic vec_t mk(input logic rst, stall, br, input logic [31:0] tgt,
                              input logic trap, halt, resume, input logic [31:0] pc,
                              input logic [1:0] st, input logic valid, mis,
                              input logic [31:0] epc, input logic [3:0] cnt);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt;
    v.trap = trap; v.halt = halt; v.resume = resume;
    v.pc = pc; v.st = st; v.valid = valid; v.mis = mis; v.epc = epc; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_stall = 1'b0; i_br_taken = 1'b0; i_br_target = '0;
    i_trap = 1'b0; i_halt = 1'b0; i_resume = 1'b0;

    //                rst stl br  tgt            trp hlt res  pc            st    v  m  epc    cnt
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        BOOT, 0, 0, 32'h0,  0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        BOOT, 0, 0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        RUN,  1, 0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h4,        RUN,  1, 0, 32'h0,  1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h8,        RUN,  1, 0, 32'h0,  2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'hC,        RUN,  1, 0, 32'h0,  3));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h10,       RUN,  1, 0, 32'h0,  4));
    vecs.push_back(mk(0, 0, 1, 32'h200,      0, 0, 0, 32'h200,      RUN,  1, 0, 32'h0,  5));
    vecs.push_back(mk(0, 1, 1, 32'h300,      0, 0, 0, 32'h200,      RUN,  1, 0, 32'h0,  5));
    vecs.push_back(mk(0, 1, 1, 32'h300,      0, 0, 0, 32'h200,      RUN,  1, 0, 32'h0,  5));
    vecs.push_back(mk(0, 1, 1, 32'h300,      0, 0, 0, 32'h200,      RUN,  1, 0, 32'h0,  5));
    vecs.push_back(mk(0, 0, 1, 32'h300,      0, 0, 0, 32'h300,      RUN,  1, 0, 32'h0,  6));
    vecs.push_back(mk(0, 0, 1, 32'h40,       0, 0, 0, 32'h40,       RUN,  1, 0, 32'h0,  7));
    vecs.push_back(mk(0, 1, 1, 32'h102,      0, 0, 0, 32'h100,      RUN,  1, 1, 32'h40, 7));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h104,      RUN,  1, 0, 32'h40, 8));
    vecs.push_back(mk(0, 0, 1, 32'h80,       0, 0, 0, 32'h80,       RUN,  1, 0, 32'h40, 9));
    vecs.push_back(mk(0, 0, 1, 32'h500,      1, 0, 0, 32'h100,      RUN,  1, 0, 32'h80, 9));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h104,      RUN,  1, 0, 32'h80, 10));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt,
            vecs[i].trap, vecs[i].halt, vecs[i].resume);
      expect_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].st, vecs[i].valid,
                 vecs[i].mis, vecs[i].epc, vecs[i].cnt);
    end

    // Halt, ignored branches/stalls while halted, resume at the held PC.
    drive(0, 0, 1, 32'h24, 0, 0, 0);  expect_all("to24",   32'h24, RUN,  1, 0, 32'h80, 11);
    drive(0, 0, 0, 32'h0,  0, 1, 0);  expect_all("halt",   32'h24, HALT, 0, 0, 32'h80, 11);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'(i % 2), 1, 32'h300, 0, 0, 0);
      expect_all("halt_hold", 32'h24, HALT, 0, 0, 32'h80, 11);
    end
    drive(0, 0, 0, 32'h0,  0, 0, 1);  expect_all("resume", 32'h24, RUN,  1, 0, 32'h80, 11);
    drive(0, 0, 0, 32'h0,  0, 0, 0);  expect_all("post_resume", 32'h28, RUN, 1, 0, 32'h80, 12);
    drive(0, 0, 1, 32'h24, 0, 0, 0);  expect_all("to24b",  32'h24, RUN,  1, 0, 32'h80, 13);
    drive(0, 0, 0, 32'h0,  0, 1, 0);  expect_all("halt2",  32'h24, HALT, 0, 0, 32'h80, 13);
    drive(0, 0, 0, 32'h0,  1, 0, 1);  expect_all("trap_vs_resume", 32'h100, RUN, 1, 0, 32'h24, 13);

    // Address wrap, reset under trap, BOOT ignoring inputs, counter wrap.
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0); expect_all("top",  32'hFFFF_FFFC, RUN, 1, 0, 32'h24, 14);
    drive(0, 0, 0, 32'h0, 0, 0, 0);         expect_all("wrap", 32'h0, RUN, 1, 0, 32'h24, 15);
    drive(1, 0, 0, 32'h0, 1, 0, 0);         expect_all("rst_trap", RV, BOOT, 0, 0, 32'h0, 0);
    drive(0, 1, 1, 32'h102, 1, 1, 0);       expect_all("boot_ign", RV, RUN, 1, 0, 32'h0, 0);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 0, 32'h0, 0, 0, 0);
      expect_all("cnt_wrap", 32'(i * 4), RUN, 1, 0, 32'h0, 4'(i));
    end

    // Randomized stimulus against the model.
    for (int i = 0; i < 800; i++) begin
      logic        r_rst, r_stall, r_br, r_trap, r_halt, r_res;
      logic [31:0] r_tgt;
      r_rst   = ($urandom_range(63) == 0);
      r_stall = ($urandom_range(3) == 0);
      r_br    = ($urandom_range(3) == 0);
      r_trap  = ($urandom_range(15) == 0);
      r_halt  = ($urandom_range(15) == 0);
      r_res   = ($urandom_range(2) == 0);
      r_tgt   = $urandom;
      if ($urandom_range(3) != 0) r_tgt[1:0] = 2'b00;
      drive(r_rst, r_stall, r_br, r_tgt, r_trap, r_halt, r_res);
      expect_all("rnd", m_pc, m_st, m_st == RUN, m_mis, m_epc, 4'(m_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
